// File: rtl/program_sequencer.sv
// Instruction-memory program counter with stall, jump, halt/resume and end-address stop.
// Optional return stack for call/ret is enabled by defining PC_CALL_STACK_EN.
module program_sequencer #(
  parameter int unsigned       ADDR_W      = 8,
  parameter int unsigned       STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR  = '0,
  parameter logic [ADDR_W-1:0] END_ADDR    = '1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic                             jump,
  input  logic                             call,
  input  logic                             ret,
  input  logic [ADDR_W-1:0]                target,
  input  logic                             halt_req,
  input  logic                             resume,
  output logic [ADDR_W-1:0]                pc_out,
  output logic                             stop,
  output logic                             stack_err,
  output logic [$clog2(STACK_DEPTH+1)-1:0] depth
);

  localparam int unsigned         DEPTH_W    = $clog2(STACK_DEPTH + 1);
  localparam logic [DEPTH_W-1:0]  FULL_DEPTH = DEPTH_W'(STACK_DEPTH);

  typedef enum logic [0:0] {StRun, StStopped} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d, pc_inc, top_entry;
  logic [DEPTH_W-1:0]  depth_q, depth_d;
  logic                err_q, err_d;
  logic                ret_req, call_req, jump_req;

  assign pc_inc = pc_q + ADDR_W'(1);

`ifdef PC_CALL_STACK_EN
  localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  // Rounded up to a power of two so the index width matches exactly.
  logic [ADDR_W-1:0] stack_q [2**IDX_W];
  logic              push;

  assign ret_req   = ret;
  assign call_req  = call;
  assign jump_req  = jump;
  assign top_entry = stack_q[IDX_W'(depth_q - DEPTH_W'(1))];
  assign push      = (state_q == StRun) && en && !halt_req && !ret && call &&
                     (depth_q != FULL_DEPTH);

  // Contents are don't-care after reset; occupancy lives in depth_q.
  always_ff @(posedge clk) begin
    if (push) begin
      stack_q[IDX_W'(depth_q)] <= pc_inc;
    end
  end
`else
  logic unused_ret;

  assign unused_ret = ret;
  assign ret_req    = 1'b0;
  assign call_req   = 1'b0;
  assign jump_req   = jump | call;
  assign top_entry  = '0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    depth_d = depth_q;
    err_d   = err_q;
    unique case (state_q)
      StRun: begin
        if (en) begin
          if (halt_req) begin
            state_d = StStopped;
          end else if (ret_req) begin
            if (depth_q != '0) begin
              pc_d    = top_entry;
              depth_d = depth_q - DEPTH_W'(1);
            end else begin
              err_d   = 1'b1;
              state_d = StStopped;
            end
          end else if (call_req) begin
            // Overflow drops the push but still redirects.
            if (depth_q != FULL_DEPTH) begin
              depth_d = depth_q + DEPTH_W'(1);
            end else begin
              err_d = 1'b1;
            end
            pc_d = target;
          end else if (jump_req) begin
            pc_d = target;
          end else if (pc_q == END_ADDR) begin
            state_d = StStopped;
          end else begin
            pc_d = pc_inc;
          end
        end
      end
      StStopped: begin
        if (resume) begin
          state_d = StRun;
          if (jump_req) begin
            pc_d = target;
          end
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRun;
      pc_q    <= RESET_ADDR;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  assign pc_out    = pc_q;
  assign stop      = (state_q == StStopped);
  assign depth     = depth_q;
  assign stack_err = err_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench for program_sequencer: directed vector tables, hand-written
// multi-cycle sequences and randomized stimulus against a queue-based reference model.
module tb_program_sequencer;

`ifdef PC_CALL_STACK_EN
  localparam bit STACK_EN = 1'b1;
`else
  localparam bit STACK_EN = 1'b0;
`endif
  localparam int SD      = 2;
  localparam int END_PC  = 255;

  logic       clk = 1'b0;
  logic       rst, en, jump, call, ret, halt_req, resume;
  logic [7:0] target;
  logic [7:0] pc_out;
  logic       stop, stack_err;
  logic [1:0] depth;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_pc;
  bit m_stop, m_err;
  int m_stk[$];

  typedef struct {
    logic       en, jump, call, ret, halt, resume;
    logic [7:0] tgt;
    logic [7:0] pc;
    logic       stp;
    logic [1:0] dep;
    logic       err;
  } vec_t;

  vec_t bld_vecs[$];
  vec_t com_vecs[$];

  program_sequencer #(
    .ADDR_W     (8),
    .STACK_DEPTH(SD),
    .RESET_ADDR (8'h00),
    .END_ADDR   (8'hFF)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .jump     (jump),
    .call     (call),
    .ret      (ret),
    .target   (target),
    .halt_req (halt_req),
    .resume   (resume),
    .pc_out   (pc_out),
    .stop     (stop),
    .stack_err(stack_err),
    .depth    (depth)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(int e, int j, int c, int r, int h, int rs, int t,
                              int p, int s, int d, int er);
    vec_t v;
    v.en = e[0]; v.jump = j[0]; v.call = c[0]; v.ret = r[0]; v.halt = h[0];
    v.resume = rs[0]; v.tgt = 8'(t); v.pc = 8'(p); v.stp = s[0]; v.dep = 2'(d);
    v.err = er[0];
    return v;
  endfunction

  task automatic check(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check_all(string tag, int p, int s, int d, int er);
    check({tag, ".pc"},    int'(pc_out),    p);
    check({tag, ".stop"},  int'(stop),      s);
    check({tag, ".depth"}, int'(depth),     d);
    check({tag, ".err"},   int'(stack_err), er);
  endtask

  task automatic drive(int e, int j, int c, int r, int h, int rs, int t);
    en = e[0]; jump = j[0]; call = c[0]; ret = r[0]; halt_req = h[0]; resume = rs[0];
    target = 8'(t);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_pc = 0; m_stop = 1'b0; m_err = 1'b0; m_stk.delete();
  endtask

  // Apply one clock of the sequencing rules to the model, from the current inputs.
  task automatic model_step();
    bit eff_jump;
    eff_jump = jump || (!STACK_EN && call);
    if (!m_stop) begin
      if (en) begin
        if (halt_req) m_stop = 1'b1;
        else if (STACK_EN && ret) begin
          if (m_stk.size() > 0) m_pc = m_stk.pop_back();
          else begin m_err = 1'b1; m_stop = 1'b1; end
        end else if (STACK_EN && call) begin
          if (m_stk.size() < SD) m_stk.push_back((m_pc + 1) % 256);
          else m_err = 1'b1;
          m_pc = int'(target);
        end else if (eff_jump) m_pc = int'(target);
        else if (m_pc == END_PC) m_stop = 1'b1;
        else m_pc = (m_pc + 1) % 256;
      end
    end else if (resume) begin
      m_stop = 1'b0;
      if (eff_jump) m_pc = int'(target);
    end
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic run_vecs(string tag, input vec_t vs[$]);
    foreach (vs[i]) begin
      drive(vs[i].en, vs[i].jump, vs[i].call, vs[i].ret, vs[i].halt, vs[i].resume,
            vs[i].tgt);
      tick();
      check_all($sformatf("%s[%0d]", tag, i), vs[i].pc, vs[i].stp, vs[i].dep, vs[i].err);
    end
  endtask

  initial begin
    // Directed tables: inputs, then expected pc/stop/depth/err after the edge.
`ifdef PC_CALL_STACK_EN
    bld_vecs.push_back(mk(1,0,1,0,0,0,'h40, 'h40,0,1,0));
    bld_vecs.push_back(mk(1,0,0,0,0,0,0,    'h41,0,1,0));
    bld_vecs.push_back(mk(1,0,0,0,0,0,0,    'h42,0,1,0));
    bld_vecs.push_back(mk(1,0,0,0,0,0,0,    'h43,0,1,0));
    bld_vecs.push_back(mk(1,0,0,1,0,0,0,    'h11,0,0,0));
    bld_vecs.push_back(mk(1,0,1,0,0,0,'h60, 'h60,0,1,0));
    bld_vecs.push_back(mk(1,0,1,0,0,0,'h70, 'h70,0,2,0));
    bld_vecs.push_back(mk(1,0,1,0,0,0,'h80, 'h80,0,2,1));
    bld_vecs.push_back(mk(1,0,0,1,0,0,0,    'h61,0,1,1));
    bld_vecs.push_back(mk(1,0,0,1,0,0,0,    'h12,0,0,1));
    bld_vecs.push_back(mk(1,0,0,1,0,0,0,    'h12,1,0,1));
    bld_vecs.push_back(mk(0,0,1,0,0,1,'h33, 'h12,0,0,1));
    bld_vecs.push_back(mk(1,0,0,0,0,0,0,    'h13,0,0,1));
`else
    bld_vecs.push_back(mk(1,0,1,0,0,0,'h50, 'h50,0,0,0));
    bld_vecs.push_back(mk(1,0,0,1,0,0,0,    'h51,0,0,0));
    bld_vecs.push_back(mk(1,1,0,1,0,0,'h70, 'h70,0,0,0));
    bld_vecs.push_back(mk(1,0,0,0,1,0,0,    'h70,1,0,0));
    bld_vecs.push_back(mk(1,0,1,0,0,1,'h33, 'h33,0,0,0));
    bld_vecs.push_back(mk(1,0,0,0,0,0,0,    'h34,0,0,0));
`endif
    com_vecs.push_back(mk(1,1,0,0,0,0,'h20, 'h20,0,0,0));
    for (int i = 0; i < 5; i++) com_vecs.push_back(mk(0,1,0,0,0,0,'h99, 'h20,0,0,0));
    com_vecs.push_back(mk(1,1,0,0,1,0,'h55, 'h20,1,0,0));
    com_vecs.push_back(mk(1,0,0,0,0,0,0,    'h20,1,0,0));
    com_vecs.push_back(mk(1,1,0,0,0,1,'h80, 'h80,0,0,0));
    com_vecs.push_back(mk(1,0,0,0,1,0,0,    'h80,1,0,0));
    com_vecs.push_back(mk(1,0,0,0,1,1,0,    'h80,0,0,0));
    com_vecs.push_back(mk(1,0,0,0,0,0,0,    'h81,0,0,0));
    com_vecs.push_back(mk(1,1,0,0,0,0,'hFF, 'hFF,0,0,0));
    com_vecs.push_back(mk(1,1,0,0,0,0,'h05, 'h05,0,0,0));
    com_vecs.push_back(mk(1,1,0,0,0,0,'hFF, 'hFF,0,0,0));
    com_vecs.push_back(mk(1,0,0,0,0,0,0,    'hFF,1,0,0));
    com_vecs.push_back(mk(1,0,0,0,0,1,0,    'hFF,0,0,0));
    com_vecs.push_back(mk(1,0,0,0,0,0,0,    'hFF,1,0,0));
    com_vecs.push_back(mk(0,0,0,0,0,1,0,    'hFF,0,0,0));
    com_vecs.push_back(mk(0,0,0,0,0,0,0,    'hFF,0,0,0));
    com_vecs.push_back(mk(1,0,0,0,0,0,0,    'hFF,1,0,0));

    // Reset state, observed before any clock edge.
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #3;
    check_all("reset", 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Free-running count to END_ADDR, then hold.
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 255; i++) begin
      tick();
      check("count.pc", int'(pc_out), i);
      check("count.stop", int'(stop), 0);
    end
    for (int i = 0; i < 11; i++) begin
      tick();
      check("endhold.pc", int'(pc_out), 255);
      check("endhold.stop", int'(stop), 1);
    end

    // Build-specific call/ret table starting at pc 0x10.
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 0);
    repeat (16) tick();
    check("pre_call.pc", int'(pc_out), 'h10);
    run_vecs("build", bld_vecs);

    do_reset();
    run_vecs("common", com_vecs);

    // Asynchronous reset mid-operation.
    do_reset();
    if (STACK_EN) begin
      drive(1, 0, 1, 0, 0, 0, 'h35); tick();
      drive(1, 0, 1, 0, 0, 0, 'h36); tick();
      drive(1, 0, 1, 0, 0, 0, 'h37); tick();
    end else begin
      drive(1, 1, 0, 0, 0, 0, 'h37); tick();
    end
    drive(1, 0, 0, 0, 1, 0, 0); tick();
    check_all("pre_rst", 'h37, 1, STACK_EN ? 2 : 0, STACK_EN ? 1 : 0);
    #2;
    rst = 1'b1;
    #1;
    check_all("async_rst", 0, 0, 0, 0);
    #1;
    rst = 1'b0;
    model_reset();

    // Randomized stimulus against the reference model.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(99) == 0) begin
        rst = 1'b1;
        #1;
        model_reset();
        check_all("rand_rst", m_pc, int'(m_stop), m_stk.size(), int'(m_err));
        rst = 1'b0;
      end
      drive(($urandom % 10) < 8, ($urandom % 10) == 0, ($urandom % 12) == 0,
            ($urandom % 12) == 0, ($urandom % 20) == 0, ($urandom % 3) == 0,
            (($urandom % 4) == 0) ? ('hF0 | ($urandom % 16)) : ($urandom % 256));
      model_step();
      tick();
      check_all("rand", m_pc, int'(m_stop), m_stk.size(), int'(m_err));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
